// File: rtl/copy_scheduler.sv
// copy_scheduler: walks a register table of sprite draw jobs once per frame
// and feeds each valid, fully on-screen job to the copy engine through a
// 4-phase execute/status handshake. Jobs are loaded into the output registers
// on entry to FETCH, so the engine-facing fields settle one cycle before
// execute rises and stay put until the job's status has cleared.
module copy_scheduler #(
  parameter int SrcAddrWidth = 14,
  parameter int Depth        = 16,
  parameter int SizeWidth    = 7,
  parameter int ScreenW      = 640,
  parameter int ScreenH      = 480,
  localparam int IdxW        = $clog2(Depth)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_sync,
  input  logic                    cmd_we,
  input  logic [IdxW-1:0]         cmd_idx,
  input  logic                    cmd_valid,
  input  logic [9:0]              cmd_x,
  input  logic [9:0]              cmd_y,
  input  logic [SizeWidth-1:0]    cmd_w,
  input  logic [SizeWidth-1:0]    cmd_h,
  input  logic [SrcAddrWidth-1:0] cmd_src,
  output logic [9:0]              dest_x_start,
  output logic [9:0]              dest_x_end,
  output logic [9:0]              dest_y_start,
  output logic [9:0]              dest_y_end,
  output logic [SrcAddrWidth-1:0] src_addr_start,
  output logic                    execute,
  input  logic                    status,
  output logic                    busy,
  output logic                    overrun,
  output logic [IdxW:0]           jobs_issued,
  output logic [IdxW:0]           jobs_skipped
);

  localparam int         CntW        = IdxW + 1;
  localparam logic [10:0] LP_SCREEN_W = 11'(ScreenW);
  localparam logic [10:0] LP_SCREEN_H = 11'(ScreenH);
  localparam logic [IdxW-1:0] LP_LAST = IdxW'(Depth - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;

  // Job table
  logic [Depth-1:0]        r_tbl_valid;
  logic [9:0]              r_tbl_x   [Depth];
  logic [9:0]              r_tbl_y   [Depth];
  logic [SizeWidth-1:0]    r_tbl_w   [Depth];
  logic [SizeWidth-1:0]    r_tbl_h   [Depth];
  logic [SrcAddrWidth-1:0] r_tbl_src [Depth];

  // Control state
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IdxW-1:0] r_idx;
  logic            r_frame_q;
  logic            w_start;

  // Current job (latched on entry to FETCH)
  logic                    r_cur_valid;
  logic                    r_w_zero;
  logic                    r_h_zero;
  logic [10:0]             r_x_end;
  logic [10:0]             r_y_end;
  logic [9:0]              r_dest_x;
  logic [9:0]              r_dest_y;
  logic [SrcAddrWidth-1:0] r_src;

  // Registered status outputs
  logic            r_execute;
  logic            r_busy;
  logic            r_overrun;
  logic [CntW-1:0] r_jobs_issued;
  logic [CntW-1:0] r_jobs_skipped;

  // Table read port (next entry to fetch, with same-cycle write forwarding)
  logic [IdxW-1:0]         w_rd_idx;
  logic                    w_rd_valid;
  logic [9:0]              w_rd_x;
  logic [9:0]              w_rd_y;
  logic [SizeWidth-1:0]    w_rd_w;
  logic [SizeWidth-1:0]    w_rd_h;
  logic [SrcAddrWidth-1:0] w_rd_src;

  // Control strobes
  logic w_reject;
  logic w_load;
  logic w_walk_begin;
  logic w_skip;
  logic w_done;
  logic w_overrun_set;

  assign w_start = frame_sync & ~r_frame_q;

  // Table valid bits: cleared by reset, written whenever cmd_we is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tbl_valid <= {Depth{1'b0}};
    end else if (cmd_we) begin
      r_tbl_valid[cmd_idx] <= cmd_valid;
    end
  end

  // Table payload: no reset needed, an entry is meaningless while its valid bit is 0
  always_ff @(posedge clk) begin
    if (cmd_we) begin
      r_tbl_x[cmd_idx]   <= cmd_x;
      r_tbl_y[cmd_idx]   <= cmd_y;
      r_tbl_w[cmd_idx]   <= cmd_w;
      r_tbl_h[cmd_idx]   <= cmd_h;
      r_tbl_src[cmd_idx] <= cmd_src;
    end
  end

  // Select the entry about to be fetched; a write landing this cycle wins
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_rd_idx = {IdxW{1'b0}};
    end else begin
      w_rd_idx = r_idx + IdxW'(1);
    end
    if (cmd_we && (cmd_idx == w_rd_idx)) begin
      w_rd_valid = cmd_valid;
      w_rd_x     = cmd_x;
      w_rd_y     = cmd_y;
      w_rd_w     = cmd_w;
      w_rd_h     = cmd_h;
      w_rd_src   = cmd_src;
    end else begin
      w_rd_valid = r_tbl_valid[w_rd_idx];
      w_rd_x     = r_tbl_x[w_rd_idx];
      w_rd_y     = r_tbl_y[w_rd_idx];
      w_rd_w     = r_tbl_w[w_rd_idx];
      w_rd_h     = r_tbl_h[w_rd_idx];
      w_rd_src   = r_tbl_src[w_rd_idx];
    end
  end

  // Bounds check on the latched job (11-bit ends so x+w cannot wrap)
  assign w_reject = r_w_zero | r_h_zero |
                    (r_x_end > LP_SCREEN_W) | (r_y_end > LP_SCREEN_H);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!r_cur_valid || w_reject) begin
          w_state_nxt = ST_ADVANCE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (status) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_RELEASE: begin
        if (!status) begin
          w_state_nxt = ST_ADVANCE;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_ADVANCE: begin
        if (r_idx == LP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: strobes that drive the datapath registers
  always_comb begin
    w_walk_begin  = 1'b0;
    w_load        = 1'b0;
    w_skip        = 1'b0;
    w_done        = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_walk_begin = w_start;
        w_load       = w_start;
      end
      ST_FETCH: begin
        w_skip        = r_cur_valid & w_reject;
        w_overrun_set = w_start;
      end
      ST_ISSUE: begin
        w_done        = status;
        w_overrun_set = w_start;
      end
      ST_RELEASE: begin
        w_overrun_set = w_start;
      end
      ST_ADVANCE: begin
        w_load        = (r_idx != LP_LAST);
        w_overrun_set = w_start;
      end
      default: begin
        w_overrun_set = w_start;
      end
    endcase
  end

  // Frame edge detector, table index and engine-facing job registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_q   <= 1'b0;
      r_idx       <= {IdxW{1'b0}};
      r_cur_valid <= 1'b0;
      r_w_zero    <= 1'b0;
      r_h_zero    <= 1'b0;
      r_x_end     <= 11'd0;
      r_y_end     <= 11'd0;
      r_dest_x    <= 10'd0;
      r_dest_y    <= 10'd0;
      r_src       <= {SrcAddrWidth{1'b0}};
    end else begin
      r_frame_q <= frame_sync;
      if (w_load) begin
        r_idx       <= w_rd_idx;
        r_cur_valid <= w_rd_valid;
        r_w_zero    <= (w_rd_w == {SizeWidth{1'b0}});
        r_h_zero    <= (w_rd_h == {SizeWidth{1'b0}});
        r_x_end     <= {1'b0, w_rd_x} + 11'(w_rd_w);
        r_y_end     <= {1'b0, w_rd_y} + 11'(w_rd_h);
        r_dest_x    <= w_rd_x;
        r_dest_y    <= w_rd_y;
        r_src       <= w_rd_src;
      end
    end
  end

  // Handshake, busy flag, sticky overrun and per-frame job counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_execute      <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_jobs_issued  <= {CntW{1'b0}};
      r_jobs_skipped <= {CntW{1'b0}};
    end else begin
      r_execute <= (w_state_nxt == ST_ISSUE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
      if (w_walk_begin) begin
        r_jobs_issued  <= {CntW{1'b0}};
        r_jobs_skipped <= {CntW{1'b0}};
      end else begin
        if (w_done) begin
          r_jobs_issued <= r_jobs_issued + CntW'(1);
        end
        if (w_skip) begin
          r_jobs_skipped <= r_jobs_skipped + CntW'(1);
        end
      end
    end
  end

  assign dest_x_start   = r_dest_x;
  assign dest_x_end     = r_x_end[9:0];
  assign dest_y_start   = r_dest_y;
  assign dest_y_end     = r_y_end[9:0];
  assign src_addr_start = r_src;
  assign execute        = r_execute;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
  assign jobs_issued    = r_jobs_issued;
  assign jobs_skipped   = r_jobs_skipped;

endmodule

// File: tb/tb_copy_scheduler.sv
// Directed testbench for copy_scheduler: a hand-driven engine model answers
// the execute/status handshake and every check is an immediate assertion
// against hand-computed values.
module tb_copy_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_sync;
  logic        cmd_we;
  logic [3:0]  cmd_idx;
  logic        cmd_valid;
  logic [9:0]  cmd_x, cmd_y;
  logic [6:0]  cmd_w, cmd_h;
  logic [13:0] cmd_src;
  logic [9:0]  dest_x_start, dest_x_end, dest_y_start, dest_y_end;
  logic [13:0] src_addr_start;
  logic        execute;
  logic        status;
  logic        busy;
  logic        overrun;
  logic [4:0]  jobs_issued, jobs_skipped;

  int n_cmp = 0;
  int n_err = 0;
  bit saw;

  always #5 clk = ~clk;

  copy_scheduler dut (
    .clk(clk), .reset_n(reset_n), .frame_sync(frame_sync),
    .cmd_we(cmd_we), .cmd_idx(cmd_idx), .cmd_valid(cmd_valid),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_src(cmd_src),
    .dest_x_start(dest_x_start), .dest_x_end(dest_x_end),
    .dest_y_start(dest_y_start), .dest_y_end(dest_y_end),
    .src_addr_start(src_addr_start), .execute(execute), .status(status),
    .busy(busy), .overrun(overrun),
    .jobs_issued(jobs_issued), .jobs_skipped(jobs_skipped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; frame_sync = 1'b0; cmd_we = 1'b0; status = 1'b0;
    cmd_idx = 4'd0; cmd_valid = 1'b0; cmd_x = 10'd0; cmd_y = 10'd0;
    cmd_w = 7'd0; cmd_h = 7'd0; cmd_src = 14'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input bit v, input int x, input int y,
                    input int w, input int h, input int src);
    @(negedge clk);
    cmd_we = 1'b1; cmd_idx = 4'(idx); cmd_valid = v;
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 7'(w); cmd_h = 7'(h); cmd_src = 14'(src);
    @(negedge clk);
    cmd_we = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic wait_exec(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (execute === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_exec_seen"}, 32'(got), 32'd1);
  endtask

  task automatic complete(input int dly, input string tag);
    bit got = 1'b0;
    repeat (dly) @(negedge clk);
    status = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (execute === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    status = 1'b0;
    chk({tag, "_exec_drop"}, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string tag, output bit saw_exec);
    bit got = 1'b0;
    saw_exec = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (execute === 1'b1) saw_exec = 1'b1;
      if (busy === 1'b0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_idle"}, 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, checked while reset is held
    reset_n = 1'b0; frame_sync = 1'b0; cmd_we = 1'b0; status = 1'b0;
    cmd_idx = 4'd0; cmd_valid = 1'b0; cmd_x = 10'd0; cmd_y = 10'd0;
    cmd_w = 7'd0; cmd_h = 7'd0; cmd_src = 14'd0;
    repeat (2) @(negedge clk);
    chk("rst_execute", 32'(execute), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_issued", 32'(jobs_issued), 32'd0);
    chk("rst_skipped", 32'(jobs_skipped), 32'd0);
    chk("rst_xs", 32'(dest_x_start), 32'd0);
    chk("rst_xe", 32'(dest_x_end), 32'd0);
    chk("rst_src", 32'(src_addr_start), 32'd0);

    // 1: single job, engine completes after 50 cycles
    do_reset();
    wr(0, 1'b1, 470, 290, 100, 100, 0);
    frame();
    chk("t1_busy", 32'(busy), 32'd1);
    wait_exec("t1");
    chk("t1_xs", 32'(dest_x_start), 32'd470);
    chk("t1_xe", 32'(dest_x_end), 32'd570);
    chk("t1_ys", 32'(dest_y_start), 32'd290);
    chk("t1_ye", 32'(dest_y_end), 32'd390);
    chk("t1_src", 32'(src_addr_start), 32'd0);
    repeat (49) @(negedge clk);
    chk("t1_exec_held", 32'(execute), 32'd1);
    complete(1, "t1");
    wait_idle("t1", saw);
    chk("t1_issued", 32'(jobs_issued), 32'd1);
    chk("t1_skipped", 32'(jobs_skipped), 32'd0);
    chk("t1_overrun", 32'(overrun), 32'd0);

    // 2: entries 0, 3, 15 valid, issued in index order
    do_reset();
    wr(0, 1'b1, 10, 20, 5, 6, 100);
    wr(3, 1'b1, 30, 40, 7, 8, 300);
    wr(15, 1'b1, 150, 160, 9, 10, 1500);
    frame();
    wait_exec("t2a");
    chk("t2a_xs", 32'(dest_x_start), 32'd10);
    chk("t2a_xe", 32'(dest_x_end), 32'd15);
    chk("t2a_src", 32'(src_addr_start), 32'd100);
    complete(3, "t2a");
    wait_exec("t2b");
    chk("t2b_xs", 32'(dest_x_start), 32'd30);
    chk("t2b_ye", 32'(dest_y_end), 32'd48);
    chk("t2b_src", 32'(src_addr_start), 32'd300);
    complete(0, "t2b");
    wait_exec("t2c");
    chk("t2c_xs", 32'(dest_x_start), 32'd150);
    chk("t2c_src", 32'(src_addr_start), 32'd1500);
    complete(2, "t2c");
    wait_idle("t2", saw);
    chk("t2_no_extra_exec", 32'(saw), 32'd0);
    chk("t2_issued", 32'(jobs_issued), 32'd3);
    chk("t2_skipped", 32'(jobs_skipped), 32'd0);

    // 3: bounds check (650>640 skip, 480<=480 issue, 640 issue, w=0 skip, 1100 skip)
    do_reset();
    wr(0, 1'b1, 600, 0, 50, 10, 1);
    wr(1, 1'b1, 0, 479, 10, 1, 7);
    wr(2, 1'b1, 540, 0, 100, 1, 8);
    wr(3, 1'b1, 0, 0, 0, 5, 9);
    wr(4, 1'b1, 1000, 0, 100, 1, 10);
    wr(5, 1'b0, 5, 5, 5, 5, 11);
    frame();
    wait_exec("t3a");
    chk("t3a_ys", 32'(dest_y_start), 32'd479);
    chk("t3a_ye", 32'(dest_y_end), 32'd480);
    chk("t3a_src", 32'(src_addr_start), 32'd7);
    complete(1, "t3a");
    wait_exec("t3b");
    chk("t3b_xs", 32'(dest_x_start), 32'd540);
    chk("t3b_xe", 32'(dest_x_end), 32'd640);
    chk("t3b_src", 32'(src_addr_start), 32'd8);
    complete(1, "t3b");
    wait_idle("t3", saw);
    chk("t3_no_extra_exec", 32'(saw), 32'd0);
    chk("t3_issued", 32'(jobs_issued), 32'd2);
    chk("t3_skipped", 32'(jobs_skipped), 32'd3);

    // 4: engine stalls across two further frame starts
    do_reset();
    wr(0, 1'b1, 1, 1, 1, 1, 3);
    wr(1, 1'b1, 2, 2, 2, 2, 4);
    frame();
    wait_exec("t4");
    repeat (20) @(negedge clk);
    frame();
    repeat (20) @(negedge clk);
    frame();
    repeat (5) @(negedge clk);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_exec_held", 32'(execute), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_no_advance", 32'(dest_x_start), 32'd1);
    complete(0, "t4a");
    wait_exec("t4b");
    chk("t4b_xs", 32'(dest_x_start), 32'd2);
    complete(0, "t4b");
    wait_idle("t4", saw);
    chk("t4_issued", 32'(jobs_issued), 32'd2);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Boundary: start one cycle after the walk ends is accepted
    do_reset();
    frame();
    repeat (32) @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    chk("bnd_late_busy", 32'(busy), 32'd1);
    chk("bnd_late_overrun", 32'(overrun), 32'd0);
    frame_sync = 1'b0;
    wait_idle("bnd_late", saw);
    // Boundary: start in the cycle the walk ends is an overrun and is ignored
    frame();
    repeat (31) @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    chk("bnd_end_overrun", 32'(overrun), 32'd1);
    chk("bnd_end_busy", 32'(busy), 32'd0);
    frame_sync = 1'b0;
    @(negedge clk);

    // 5: asynchronous reset during ISSUE clears outputs and table
    do_reset();
    wr(0, 1'b1, 100, 100, 10, 10, 5);
    frame();
    wait_exec("t5");
    #2 reset_n = 1'b0;
    #1;
    chk("t5_exec_async", 32'(execute), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_xs_async", 32'(dest_x_start), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    frame();
    wait_idle("t5", saw);
    chk("t5_nothing_issued", 32'(saw), 32'd0);
    chk("t5_issued", 32'(jobs_issued), 32'd0);
    chk("t5_skipped", 32'(jobs_skipped), 32'd0);

    // 6: rewrites during entry 0's ISSUE: entry 1 takes new data, entry 0 unaffected
    do_reset();
    wr(0, 1'b1, 5, 5, 5, 5, 1);
    wr(1, 1'b1, 100, 100, 10, 10, 55);
    frame();
    wait_exec("t6a");
    chk("t6a_xs", 32'(dest_x_start), 32'd5);
    wr(1, 1'b1, 200, 210, 20, 30, 66);
    wr(0, 1'b1, 9, 9, 9, 9, 2);
    chk("t6a_inflight_xs", 32'(dest_x_start), 32'd5);
    chk("t6a_inflight_src", 32'(src_addr_start), 32'd1);
    chk("t6a_exec_held", 32'(execute), 32'd1);
    complete(0, "t6a");
    wait_exec("t6b");
    chk("t6b_xs", 32'(dest_x_start), 32'd200);
    chk("t6b_xe", 32'(dest_x_end), 32'd220);
    chk("t6b_ys", 32'(dest_y_start), 32'd210);
    chk("t6b_ye", 32'(dest_y_end), 32'd240);
    chk("t6b_src", 32'(src_addr_start), 32'd66);
    complete(1, "t6b");
    wait_idle("t6", saw);
    chk("t6_issued", 32'(jobs_issued), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
